// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer driving the Datapath control ports.
// Fetch runs T0-T2, execute runs T3-T7. Only the step register is clocked.
// All strobes decode combinationally from the step and the opcode IR[31:27].
//
// Ports:
//   Clock, Clear       rising-edge clock, async active-high reset
//   IR                 current instruction (opcode in the top OP_W bits)
//   CON_FF             branch condition, gates PCin in the last brx step
//   Stop               level halt request, taken only at an instruction boundary
//   Run                1 while sequencing, 0 in RESET/HALT
//   alu_op             ALU operation select (Datapath opcode encoding)
//   remaining outputs  one-to-one Datapath load/drive/select strobes
module control_unit #(
    parameter int OP_W = 5,
    parameter int IR_W = 32
) (
    input  logic            Clock,
    input  logic            Clear,
    input  logic [IR_W-1:0] IR,
    input  logic            CON_FF,
    input  logic            Stop,
    output logic            Run,
    output logic [OP_W-1:0] alu_op,
    output logic            Read, Write,
    output logic            PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin,
    output logic            Out_Portin, In_Portin, Rin, CONin,
    output logic            PCout, MDRout, Zhiout, Zlowout, HIout, LOout,
    output logic            Cout, InPortout, Rout, BAout,
    output logic            Gra, Grb, Grc, IncPC
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [OP_W-1:0] OP_LD   = OP_W'(0),  OP_LDI  = OP_W'(1),
                                OP_ST   = OP_W'(2),  OP_ADD  = OP_W'(3),
                                OP_AND  = OP_W'(5),  OP_OR   = OP_W'(6),
                                OP_SHL  = OP_W'(11), OP_ADDI = OP_W'(12),
                                OP_ANDI = OP_W'(13), OP_ORI  = OP_W'(14),
                                OP_DIV  = OP_W'(15), OP_MUL  = OP_W'(16),
                                OP_NEG  = OP_W'(17), OP_NOT  = OP_W'(18),
                                OP_BRX  = OP_W'(19), OP_JR   = OP_W'(20),
                                OP_JAL  = OP_W'(21), OP_IN   = OP_W'(22),
                                OP_OUT  = OP_W'(23), OP_MFHI = OP_W'(24),
                                OP_MFLO = OP_W'(25), OP_HALT = OP_W'(27);

    state_t          state, nxt, fin;
    logic [OP_W-1:0] op;
    logic [2:0]      last;      // final step number of the current instruction
    logic            is_alu, is_imm;
    logic            unused_ir;

    assign op        = IR[IR_W-1 -: OP_W];
    assign unused_ir = ^IR[IR_W-OP_W-1:0];
    assign is_alu    = (op >= OP_ADD) && (op <= OP_SHL);
    assign is_imm    = (op >= OP_ADDI) && (op <= OP_ORI);
    // Stop is only looked at here, so a running instruction always completes.
    assign fin       = Stop ? S_HALT : S_T0;

    always_comb begin
        last = 3'd2;                       // nop, 111xx and halt end after fetch
        if (is_alu || is_imm) last = 3'd5;
        case (op)
            OP_LD, OP_ST:                   last = 3'd7;
            OP_LDI:                         last = 3'd5;
            OP_MUL, OP_DIV, OP_BRX:         last = 3'd6;
            OP_NEG, OP_NOT, OP_JAL:         last = 3'd4;
            OP_JR, OP_IN, OP_OUT,
            OP_MFHI, OP_MFLO:               last = 3'd3;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) state <= S_RESET;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_RESET: nxt = S_T0;
            S_T0:    nxt = S_T1;
            S_T1:    nxt = S_T2;
            S_T2:    nxt = (op == OP_HALT) ? S_HALT : (last == 3'd2) ? fin : S_T3;
            S_T3:    nxt = (last == 3'd3) ? fin : S_T4;
            S_T4:    nxt = (last == 3'd4) ? fin : S_T5;
            S_T5:    nxt = (last == 3'd5) ? fin : S_T6;
            S_T6:    nxt = (last == 3'd6) ? fin : S_T7;
            S_T7:    nxt = fin;
            S_HALT:  nxt = S_HALT;
            default: nxt = S_RESET;
        endcase
    end

    always_comb begin
        Run = 1'b0; alu_op = '0; Read = 1'b0; Write = 1'b0;
        PCin = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; HIin = 1'b0; LOin = 1'b0; Out_Portin = 1'b0;
        In_Portin = 1'b0; Rin = 1'b0; CONin = 1'b0;
        PCout = 1'b0; MDRout = 1'b0; Zhiout = 1'b0; Zlowout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; Cout = 1'b0; InPortout = 1'b0;
        Rout = 1'b0; BAout = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; IncPC = 1'b0;
        Run = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: case (op)
                OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                OP_MUL, OP_DIV:  begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                OP_NEG, OP_NOT:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
                OP_BRX:          begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                OP_JR:           begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                OP_JAL:          begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                OP_IN:           begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_OUT:          begin Gra = 1'b1; Rout = 1'b1; Out_Portin = 1'b1; end
                OP_MFHI:         begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_MFLO:         begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: if (is_alu || is_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            endcase
            S_T4: case (op)
                OP_LD, OP_LDI, OP_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
                OP_MUL, OP_DIV:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
                OP_NEG, OP_NOT:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_BRX:          begin PCout = 1'b1; Yin = 1'b1; end
                OP_JAL:          begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                default: begin
                    if (is_alu) begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
                    if (is_imm) begin
                        Cout = 1'b1; Zin = 1'b1;
                        // immediate forms reuse the register-form ALU encodings
                        alu_op = (op == OP_ANDI) ? OP_AND : (op == OP_ORI) ? OP_OR : OP_ADD;
                    end
                end
            endcase
            S_T5: case (op)
                OP_LD, OP_ST:    begin Zlowout = 1'b1; MARin = 1'b1; end
                OP_LDI:          begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_MUL, OP_DIV:  begin Zlowout = 1'b1; LOin = 1'b1; end
                OP_BRX:          begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
                default: if (is_alu || is_imm) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            endcase
            S_T6: case (op)
                OP_LD:           begin Read = 1'b1; MDRin = 1'b1; end
                // Read stays low so MDR loads from the bus rather than memory
                OP_ST:           begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                OP_MUL, OP_DIV:  begin Zhiout = 1'b1; HIin = 1'b1; end
                OP_BRX:          begin Zlowout = 1'b1; PCin = CON_FF; end
                default: ;
            endcase
            S_T7: case (op)
                OP_LD:           begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_ST:           Write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
    logic        Clock = 1'b0, Clear = 1'b1, CON_FF = 1'b0, Stop = 1'b0;
    logic [31:0] IR = '0;
    logic        Run;
    logic [4:0]  alu_op;
    logic Read, Write, PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin;
    logic Out_Portin, In_Portin, Rin, CONin, PCout, MDRout, Zhiout, Zlowout;
    logic HIout, LOout, Cout, InPortout, Rout, BAout, Gra, Grb, Grc, IncPC;

    control_unit #(.OP_W(5), .IR_W(32)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .Run(Run), .alu_op(alu_op), .Read(Read), .Write(Write),
        .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .MARin(MARin),
        .MDRin(MDRin), .HIin(HIin), .LOin(LOin), .Out_Portin(Out_Portin),
        .In_Portin(In_Portin), .Rin(Rin), .CONin(CONin), .PCout(PCout),
        .MDRout(MDRout), .Zhiout(Zhiout), .Zlowout(Zlowout), .HIout(HIout),
        .LOout(LOout), .Cout(Cout), .InPortout(InPortout), .Rout(Rout),
        .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC)
    );

    always #5 Clock = ~Clock;

    // Expected/actual word: {Run, alu_op, 28 strobes}
    localparam logic [33:0] B_READ = 34'd1 << 0,  B_WRITE = 34'd1 << 1,
        B_GRA  = 34'd1 << 2,  B_GRB  = 34'd1 << 3,  B_GRC   = 34'd1 << 4,
        B_INCPC= 34'd1 << 5,  B_PCIN = 34'd1 << 6,  B_IRIN  = 34'd1 << 7,
        B_YIN  = 34'd1 << 8,  B_ZIN  = 34'd1 << 9,  B_MARIN = 34'd1 << 10,
        B_MDRIN= 34'd1 << 11, B_HIIN = 34'd1 << 12, B_LOIN  = 34'd1 << 13,
        B_OUTP = 34'd1 << 14, B_INPIN= 34'd1 << 15, B_RIN   = 34'd1 << 16,
        B_CONIN= 34'd1 << 17, B_PCOUT= 34'd1 << 18, B_MDROUT= 34'd1 << 19,
        B_ZHI  = 34'd1 << 20, B_ZLO  = 34'd1 << 21, B_HIOUT = 34'd1 << 22,
        B_LOOUT= 34'd1 << 23, B_COUT = 34'd1 << 24, B_INPOUT= 34'd1 << 25,
        B_ROUT = 34'd1 << 26, B_BAOUT= 34'd1 << 27, R       = 34'd1 << 33;

    function automatic logic [33:0] alu(input int x);
        return 34'(x) << 28;
    endfunction

    logic [33:0] act;
    assign act = {Run, alu_op, BAout, Rout, InPortout, Cout, LOout, HIout, Zlowout,
                  Zhiout, MDRout, PCout, CONin, Rin, In_Portin, Out_Portin, LOin,
                  HIin, MDRin, MARin, Zin, Yin, IRin, PCin, IncPC, Grc, Grb, Gra,
                  Write, Read};

    typedef struct { logic [33:0] v; string tag; } exp_t;
    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;

    // Monitor: outputs are Moore, so every cycle presents one response.
    always @(negedge Clock) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.tag, act, e.v);
            end
        end
    end

    task automatic cyc(input logic [31:0] ir, input logic clr, input logic stp,
                       input logic con, input logic [33:0] v, input string tag);
        exp_t e;
        @(posedge Clock); #1;
        IR = ir; Clear = clr; Stop = stp; CON_FF = con;
        e.v = v; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] ir, input logic con, input string tag);
        cyc(ir, 0, 0, con, R | B_PCOUT | B_MARIN | B_INCPC | B_ZIN, {tag, "_t0"});
        cyc(ir, 0, 0, con, R | B_ZLO | B_PCIN | B_READ | B_MDRIN, {tag, "_t1"});
        cyc(ir, 0, 0, con, R | B_MDROUT | B_IRIN, {tag, "_t2"});
    endtask

    localparam logic [31:0] I_ADD = 32'h18A00000, I_LD = 32'h00000000,
        I_ST = 32'h10000000, I_ADDI = 32'h60000000, I_ANDI = 32'h68000000,
        I_MUL = 32'h80000000, I_NEG = 32'h88000000, I_BRX = 32'h98000000,
        I_JAL = 32'hA8000000, I_IN = 32'hB0000000, I_NOP = 32'hD0000000,
        I_HALT = 32'hD8000000, I_X31 = 32'hF8000000;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset held two cycles, then one RESET cycle after release
        cyc(0, 1, 0, 0, '0, "rst0");
        cyc(0, 1, 0, 0, '0, "rst1");
        cyc(0, 0, 0, 0, '0, "rst_rel");
        // add R1,R2,R3
        fetch(I_ADD, 0, "add");
        cyc(I_ADD, 0, 0, 0, R | B_GRB | B_ROUT | B_YIN, "add_t3");
        cyc(I_ADD, 0, 0, 0, R | B_GRC | B_ROUT | B_ZIN | alu(3), "add_t4");
        cyc(I_ADD, 0, 0, 0, R | B_ZLO | B_GRA | B_RIN, "add_t5");
        // ld
        fetch(I_LD, 0, "ld");
        cyc(I_LD, 0, 0, 0, R | B_GRB | B_BAOUT | B_YIN, "ld_t3");
        cyc(I_LD, 0, 0, 0, R | B_COUT | B_ZIN | alu(3), "ld_t4");
        cyc(I_LD, 0, 0, 0, R | B_ZLO | B_MARIN, "ld_t5");
        cyc(I_LD, 0, 0, 0, R | B_READ | B_MDRIN, "ld_t6");
        cyc(I_LD, 0, 0, 0, R | B_MDROUT | B_GRA | B_RIN, "ld_t7");
        // brx taken, then not taken
        for (int k = 1; k >= 0; k--) begin
            logic c;
            c = 1'(k);
            fetch(I_BRX, c, "brx");
            cyc(I_BRX, 0, 0, c, R | B_GRA | B_ROUT | B_CONIN, "brx_t3");
            cyc(I_BRX, 0, 0, c, R | B_PCOUT | B_YIN, "brx_t4");
            cyc(I_BRX, 0, 0, c, R | B_COUT | B_ZIN | alu(3), "brx_t5");
            cyc(I_BRX, 0, 0, c, R | B_ZLO | (c ? B_PCIN : 34'd0), "brx_t6");
        end
        // addi / andi
        fetch(I_ADDI, 0, "addi");
        cyc(I_ADDI, 0, 0, 0, R | B_GRB | B_ROUT | B_YIN, "addi_t3");
        cyc(I_ADDI, 0, 0, 0, R | B_COUT | B_ZIN | alu(3), "addi_t4");
        cyc(I_ADDI, 0, 0, 0, R | B_ZLO | B_GRA | B_RIN, "addi_t5");
        fetch(I_ANDI, 0, "andi");
        cyc(I_ANDI, 0, 0, 0, R | B_GRB | B_ROUT | B_YIN, "andi_t3");
        cyc(I_ANDI, 0, 0, 0, R | B_COUT | B_ZIN | alu(5), "andi_t4");
        cyc(I_ANDI, 0, 0, 0, R | B_ZLO | B_GRA | B_RIN, "andi_t5");
        // mul
        fetch(I_MUL, 0, "mul");
        cyc(I_MUL, 0, 0, 0, R | B_GRA | B_ROUT | B_YIN, "mul_t3");
        cyc(I_MUL, 0, 0, 0, R | B_GRB | B_ROUT | B_ZIN | alu(16), "mul_t4");
        cyc(I_MUL, 0, 0, 0, R | B_ZLO | B_LOIN, "mul_t5");
        cyc(I_MUL, 0, 0, 0, R | B_ZHI | B_HIIN, "mul_t6");
        // neg, jal, in
        fetch(I_NEG, 0, "neg");
        cyc(I_NEG, 0, 0, 0, R | B_GRB | B_ROUT | B_ZIN | alu(17), "neg_t3");
        cyc(I_NEG, 0, 0, 0, R | B_ZLO | B_GRA | B_RIN, "neg_t4");
        fetch(I_JAL, 0, "jal");
        cyc(I_JAL, 0, 0, 0, R | B_PCOUT | B_GRB | B_RIN, "jal_t3");
        cyc(I_JAL, 0, 0, 0, R | B_GRA | B_ROUT | B_PCIN, "jal_t4");
        fetch(I_IN, 0, "in");
        cyc(I_IN, 0, 0, 0, R | B_INPOUT | B_GRA | B_RIN, "in_t3");
        // st aborted by Clear in T6: Write never appears
        fetch(I_ST, 0, "st");
        cyc(I_ST, 0, 0, 0, R | B_GRB | B_BAOUT | B_YIN, "st_t3");
        cyc(I_ST, 0, 0, 0, R | B_COUT | B_ZIN | alu(3), "st_t4");
        cyc(I_ST, 0, 0, 0, R | B_ZLO | B_MARIN, "st_t5");
        cyc(I_ST, 1, 0, 0, '0, "st_clr_t6");
        cyc(I_ST, 0, 0, 0, '0, "st_rst");
        // add with Stop raised in T4: completes T5 then halts
        fetch(I_ADD, 0, "adds");
        cyc(I_ADD, 0, 0, 0, R | B_GRB | B_ROUT | B_YIN, "adds_t3");
        cyc(I_ADD, 0, 1, 0, R | B_GRC | B_ROUT | B_ZIN | alu(3), "adds_t4");
        cyc(I_ADD, 0, 1, 0, R | B_ZLO | B_GRA | B_RIN, "adds_t5");
        for (int k = 0; k < 3; k++) cyc(I_ADD, 0, 0, 0, '0, "halt_hold");
        cyc(I_ADD, 1, 0, 0, '0, "halt_clr");
        cyc(I_ADD, 0, 0, 0, '0, "halt_rst");
        // halt opcode enters HALT after T2
        fetch(I_HALT, 0, "haltop");
        cyc(I_HALT, 0, 0, 0, '0, "haltop_h0");
        cyc(I_HALT, 0, 0, 0, '0, "haltop_h1");
        cyc(I_HALT, 1, 0, 0, '0, "haltop_clr");
        cyc(I_NOP, 0, 0, 0, '0, "haltop_rst");
        // nop and undefined opcode end at T2
        fetch(I_NOP, 0, "nop");
        fetch(I_X31, 0, "x31");
        fetch(I_ADD, 0, "tail");
        @(negedge Clock);
        @(negedge Clock);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
